// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the three-digit multiplexed
//               seven-segment scan driver. Segment patterns are active-low
//               and ordered {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Number of scanned digits (hundreds, tens, ones)
    localparam int C_DIGITS = 3;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] C_SEG_0    = 7'b1000000;
    localparam logic [6:0] C_SEG_1    = 7'b1111001;
    localparam logic [6:0] C_SEG_2    = 7'b0100100;
    localparam logic [6:0] C_SEG_3    = 7'b0110000;
    localparam logic [6:0] C_SEG_4    = 7'b0011001;
    localparam logic [6:0] C_SEG_5    = 7'b0010010;
    localparam logic [6:0] C_SEG_6    = 7'b0000010;
    localparam logic [6:0] C_SEG_7    = 7'b1111000;
    localparam logic [6:0] C_SEG_8    = 7'b0000000;
    localparam logic [6:0] C_SEG_9    = 7'b0010000;
    localparam logic [6:0] C_SEG_DASH = 7'b0111111;

    // Everything dark
    localparam logic [6:0] C_SEG_OFF  = 7'h7F;
    localparam logic [2:0] C_AN_OFF   = 3'b111;

    // Scan state: digit lit, or all-off guard gap between digits
    typedef enum logic [0:0] {
        ST_ON    = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    // One-cold anode enable for a digit index (2 = hundreds, 1 = tens, 0 = ones)
    function automatic logic [2:0] an_select(input logic [1:0] idx);
        logic [2:0] an_v;
        an_v = C_AN_OFF;
        case (idx)
            2'd2:    an_v = 3'b011;
            2'd1:    an_v = 3'b101;
            2'd0:    an_v = 3'b110;
            default: an_v = C_AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD digit to active-low seven-segment pattern.
//               Codes 10..15 are not valid BCD and render as a dash so a
//               corrupted upstream value is visible rather than misleading.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pattern lookup, dash for any non-decimal code
    always_comb begin
        o_seg = C_SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = C_SEG_0;
            4'd1:    o_seg = C_SEG_1;
            4'd2:    o_seg = C_SEG_2;
            4'd3:    o_seg = C_SEG_3;
            4'd4:    o_seg = C_SEG_4;
            4'd5:    o_seg = C_SEG_5;
            4'd6:    o_seg = C_SEG_6;
            4'd7:    o_seg = C_SEG_7;
            4'd8:    o_seg = C_SEG_8;
            4'd9:    o_seg = C_SEG_9;
            default: o_seg = C_SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg7_scan
// Description : Three-digit multiplexed seven-segment driver. A BCD triple is
//               taken over a valid/ready handshake into a pending buffer and
//               promoted to the display register only at the frame boundary
//               (last guard cycle of the ones digit), so a frame never mixes
//               digits of two different numbers. Each digit is lit for
//               ON_CYCLES, followed by GUARD_CYCLES of all-off to suppress
//               ghosting. seg/an/frame_done are registered, one cycle behind
//               the scan state.
//               Optional macro LEADING_ZERO_BLANK_EN: blank a leading zero in
//               the hundreds slot, and in the tens slot when hundreds is also
//               zero. Slot timing is unaffected.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int ON_CYCLES    = 50000,   // >= 1
    parameter int GUARD_CYCLES = 2        // >= 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    // Slot counter only needs to reach the longer of the two slot lengths
    localparam int MAX_CYCLES = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [1:0]       C_FIRST_DIG  = 2'(C_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [11:0]      r_pend;
    logic             r_pend_full;
    logic [11:0]      r_disp;
    logic [1:0]       r_digit;
    logic [CNT_W-1:0] r_cnt;
    scan_state_t      r_state;

    logic             w_accept;
    logic             w_on_end;
    logic             w_guard_end;
    logic             w_frame_end;
    logic [3:0]       w_sel_bcd;
    logic [6:0]       w_sel_seg;
    logic             w_blank;

    // ------------------------------------------------------------------
    // Handshake and slot-end decodes
    // ------------------------------------------------------------------
    assign in_ready    = !r_pend_full;
    assign w_accept    = in_valid && !r_pend_full;
    assign w_on_end    = (r_state == ST_ON)    && (r_cnt == C_ON_LAST);
    assign w_guard_end = (r_state == ST_GUARD) && (r_cnt == C_GUARD_LAST);
    assign w_frame_end = w_guard_end && (r_digit == 2'd0);

    // Select the BCD nibble of the digit currently being scanned
    always_comb begin
        w_sel_bcd = r_disp[3:0];
        case (r_digit)
            2'd2:    w_sel_bcd = r_disp[11:8];
            2'd1:    w_sel_bcd = r_disp[7:4];
            default: w_sel_bcd = r_disp[3:0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_sel_bcd),
        .o_seg (w_sel_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic w_h_zero;
    logic w_t_zero;
    assign w_h_zero = (r_disp[11:8] == 4'd0);
    assign w_t_zero = (r_disp[7:4]  == 4'd0);
    // Ones is never blanked so a value of zero still shows a single "0"
    assign w_blank  = ((r_digit == 2'd2) && w_h_zero) ||
                      ((r_digit == 2'd1) && w_h_zero && w_t_zero);
`else
    assign w_blank  = 1'b0;
`endif

    // Pending buffer: capture on accept, release at the frame boundary.
    // Accept and release never coincide because in_ready is low while full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= {hundreds, tens, ones};
            r_pend_full <= 1'b1;
        end else if (w_frame_end && r_pend_full) begin
            r_pend_full <= 1'b0;
        end
    end

    // Display register: only updated at the frame boundary so frames never tear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp <= '0;
        end else if (w_frame_end && r_pend_full) begin
            r_disp <= r_pend;
        end
    end

    // Scan FSM with registered segment/anode/frame outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ON;
            r_digit    <= C_FIRST_DIG;
            r_cnt      <= '0;
            seg        <= C_SEG_OFF;
            an         <= C_AN_OFF;
            frame_done <= 1'b0;
        end else begin
            // Outputs mirror the current state, landing one cycle later
            frame_done <= w_frame_end;
            if ((r_state == ST_ON) && !w_blank) begin
                seg <= w_sel_seg;
                an  <= an_select(r_digit);
            end else begin
                seg <= C_SEG_OFF;
                an  <= C_AN_OFF;
            end

            if (r_state == ST_ON) begin
                if (w_on_end) begin
                    r_state <= ST_GUARD;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end else begin
                if (w_guard_end) begin
                    r_state <= ST_ON;
                    r_cnt   <= '0;
                    r_digit <= (r_digit == 2'd0) ? C_FIRST_DIG : (r_digit - 2'd1);
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule : bcd_seg7_scan
`default_nettype wire

// File: tb/tb_bcd_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seg7_scan
// Description : Self-checking bench for bcd_seg7_scan with ON_CYCLES=4 and
//               GUARD_CYCLES=1 (15-cycle frame). Triples are pushed to a
//               scoreboard queue when driven and popped when the frame that
//               should show them begins. Honours LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg7_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    bcd_seg7_scan #(
        .ON_CYCLES    (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    // Reference active-low patterns {g,f,e,d,c,b,a}
    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; offers one triple for one cycle, expects acceptance
    task automatic send(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        chk("pre_send_ready", {15'd0, in_ready}, 16'd1);
        hundreds = h;
        tens     = t;
        ones     = o;
        in_valid = 1'b1;
        sb_q.push_back({h, t, o});
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_send_ready", {15'd0, in_ready}, 16'd0);
    endtask

    // Advance to the next cycle with frame_done high, bounded
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("frame_done_timeout", {15'd0, seen}, 16'd1);
    endtask

    task automatic pop_exp(output logic [11:0] v);
        if (sb_q.size() == 0) v = 12'hFFF;
        else                  v = sb_q.pop_front();
    endtask

    // Check the 15 output cycles following a frame start (or reset release).
    // k=1..4 hundreds, 5 gap, 6..9 tens, 10 gap, 11..14 ones, 15 gap + frame_done.
    task automatic check_frame(input logic [11:0] v);
        int         d;
        logic       lit;
        logic [3:0] dv;
        logic [6:0] eseg;
        logic [2:0] ean;
        logic       efd;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            dv = 4'd0;
            if (k >= 1 && k <= 4)        begin d = 2; dv = v[11:8]; end
            else if (k >= 6 && k <= 9)   begin d = 1; dv = v[7:4];  end
            else if (k >= 11 && k <= 14) begin d = 0; dv = v[3:0];  end
            else                         d = -1;
            lit = (d >= 0);
`ifdef LEADING_ZERO_BLANK_EN
            if (d == 2 && v[11:8] == 4'd0) lit = 1'b0;
            if (d == 1 && v[11:8] == 4'd0 && v[7:4] == 4'd0) lit = 1'b0;
`endif
            eseg = lit ? pat(dv) : 7'h7F;
            ean  = !lit ? 3'b111 : (d == 2) ? 3'b011 : (d == 1) ? 3'b101 : 3'b110;
            efd  = (k == 15);
            chk($sformatf("frame_%03h_k%0d", v, k),
                {5'd0, seg, an, frame_done}, {5'd0, eseg, ean, efd});
        end
    endtask

    initial begin
        logic [11:0] e;
        reset    = 1'b1;
        in_valid = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg",   {9'd0, seg},         16'h007F);
        chk("rst_an",    {13'd0, an},         16'h0007);
        chk("rst_fd",    {15'd0, frame_done}, 16'h0000);
        chk("rst_ready", {15'd0, in_ready},   16'h0001);
        reset = 1'b0;

        // Idle frames show 000 with a 15-cycle frame_done period
        check_frame(12'h000);
        check_frame(12'h000);

        // 2/5/5 offered mid-frame appears only from the next frame
        repeat (5) @(negedge clk);
        send(4'd2, 4'd5, 4'd5);
        wait_fd();
        chk("ready_after_boundary_255", {15'd0, in_ready}, 16'd1);
        pop_exp(e);
        check_frame(e);

        // 1/2/3 followed at once by 4/5/6: second stalls until boundary
        send(4'd1, 4'd2, 4'd3);
        hundreds = 4'd4;
        tens     = 4'd5;
        ones     = 4'd6;
        in_valid = 1'b1;
        sb_q.push_back(12'h456);
        repeat (3) @(negedge clk);
        chk("stall_ready", {15'd0, in_ready}, 16'd0);
        wait_fd();
        chk("ready_after_boundary_123", {15'd0, in_ready}, 16'd1);
        pop_exp(e);
        check_frame(e);
        pop_exp(e);
        check_frame(e);

        // Leading zeros (blanked only when the macro is defined)
        send(4'd0, 4'd0, 4'd7);
        wait_fd();
        pop_exp(e);
        check_frame(e);

        // Non-BCD codes render as dash
        send(4'd12, 4'd3, 4'd15);
        wait_fd();
        pop_exp(e);
        check_frame(e);

        // Reset during the tens slot with a pending value outstanding
        send(4'd9, 4'd8, 4'd7);
        repeat (6) @(negedge clk);
        chk("mid_tens_an", {13'd0, an}, 16'h0005);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_seg",   {9'd0, seg},         16'h007F);
        chk("mid_rst_an",    {13'd0, an},         16'h0007);
        chk("mid_rst_fd",    {15'd0, frame_done}, 16'h0000);
        chk("mid_rst_ready", {15'd0, in_ready},   16'h0001);
        reset = 1'b0;
        check_frame(12'h000);
        check_frame(12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_seg7_scan
`default_nettype wire
